// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types, glyph constants and helpers for the seven-segment controller
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Active-low {g,f,e,d,c,b,a} glyphs for one hex nibble.
    function automatic logic [6:0] digit_to_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0100000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    // Enough BCD digits to hold any w-bit unsigned value, plus one spare.
    function automatic int bcd_digits(input int w);
        return w / 3 + 2;
    endfunction

endpackage

// File: rtl/seg7_dabble.sv
// rtl/seg7_dabble.sv - sequential double-dabble binary-to-BCD engine, one bit per cycle
module seg7_dabble
    import seg7_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int BCD_DIGITS = bcd_digits(DATA_W)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DATA_W-1:0]       bin,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd
);

    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] sh_q;
    logic [BCD_W-1:0]  bcd_q;
    logic [BCD_W-1:0]  adj;
    logic [CNT_W-1:0]  cnt_q;

    always_comb begin
        adj = '0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                      : bcd_q[4*i +: 4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            sh_q  <= bin;
            bcd_q <= '0;
            cnt_q <= CNT_W'(DATA_W);
        end else if (cnt_q != '0) begin
            sh_q  <= sh_q << 1;
            bcd_q <= {adj[BCD_W-2:0], sh_q[DATA_W-1]};
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // High during the final step; bcd holds the result after that edge.
    assign done = (cnt_q == CNT_W'(1));
    assign bcd  = bcd_q;

endmodule

// File: rtl/seg7_display_ctrl.sv
// rtl/seg7_display_ctrl.sv - multi-digit hex/decimal seven-segment controller with blanking and blink
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_DIGITS = 8,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [DATA_W-1:0]       i_data,
    input  logic                    i_mode,
    input  logic                    i_blank_lz,
    input  logic                    i_blink_en,
    output logic                    o_overflow,
    output logic [7*NUM_DIGITS-1:0] o_seg
);

    localparam int BCD_DIGITS = bcd_digits(DATA_W);
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int DIG_W      = 4 * NUM_DIGITS;
    localparam int HEX_PAD_W  = DIG_W + DATA_W;
    localparam int DEC_PAD_W  = DIG_W + BCD_W;
    localparam int BLK_W      = $clog2(BLINK_DIV);

    state_t state_q, state_d;
    logic   accept;
    logic   commit;
    logic   dab_start;
    logic   dab_done;

    logic [BCD_W-1:0]  dab_bcd;
    logic [DATA_W-1:0] data_q;
    logic              mode_q;
    logic              blank_q;

    logic [DIG_W-1:0]  dig_q;
    logic              ovf_q;
    logic              lz_q;

    logic [DIG_W-1:0]     dig_d;
    logic                 ovf_d;
    logic [HEX_PAD_W-1:0] hex_pad;
    logic [DEC_PAD_W-1:0] dec_pad;

    logic [BLK_W-1:0] blk_cnt_q;
    logic             phase_q;
    logic [6:0]       glyph [NUM_DIGITS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = i_mode ? CONVERT : COMMIT;
            CONVERT: if (dab_done) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_ready   = (state_q == IDLE);
        accept    = i_valid && (state_q == IDLE);
        dab_start = accept && i_mode;
        commit    = (state_q == COMMIT);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q  <= '0;
            mode_q  <= 1'b0;
            blank_q <= 1'b0;
        end else if (accept) begin
            data_q  <= i_data;
            mode_q  <= i_mode;
            blank_q <= i_blank_lz;
        end
    end

    seg7_dabble #(
        .DATA_W     (DATA_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_dabble (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .start (dab_start),
        .bin   (i_data),
        .done  (dab_done),
        .bcd   (dab_bcd)
    );

    // Zero-extend both sources so digits past the value width read as 0
    // and everything above the physical digits feeds the overflow test.
    always_comb begin
        hex_pad = HEX_PAD_W'(data_q);
        dec_pad = DEC_PAD_W'(dab_bcd);
        if (mode_q) begin
            dig_d = dec_pad[DIG_W-1:0];
            ovf_d = |dec_pad[DEC_PAD_W-1:DIG_W];
        end else begin
            dig_d = hex_pad[DIG_W-1:0];
            ovf_d = |hex_pad[HEX_PAD_W-1:DIG_W];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dig_q <= '0;
            ovf_q <= 1'b0;
            lz_q  <= 1'b0;
        end else if (commit) begin
            dig_q <= dig_d;
            ovf_q <= ovf_d;
            lz_q  <= blank_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            blk_cnt_q <= '0;
            phase_q   <= 1'b0;
        end else if (blk_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
            blk_cnt_q <= '0;
            phase_q   <= ~phase_q;
        end else begin
            blk_cnt_q <= blk_cnt_q + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_glyph
        assign glyph[g] = digit_to_glyph(dig_q[4*g +: 4]);
    end

    // Scan from the top digit down; once a nonzero digit (or digit 0) is
    // seen, every lower digit is shown even under blanking.
    always_comb begin
        logic       seen;
        logic [6:0] seg;
        o_seg = '0;
        seen  = 1'b0;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            seen = seen | (dig_q[4*d +: 4] != 4'd0) | (d == 0);
            if (ovf_q)              seg = SEG_DASH;
            else if (seen || !lz_q) seg = glyph[d];
            else                    seg = SEG_BLANK;
            if (i_blink_en && phase_q) seg = SEG_BLANK;
            o_seg[7*d +: 7] = seg;
        end
    end

    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// tb/tb_seg7_display_ctrl.sv - directed self-checking bench for seg7_display_ctrl
module tb_seg7_display_ctrl;

    localparam int DATA_W     = 32;
    localparam int NUM_DIGITS = 8;
    localparam int BLINK_DIV  = 4;

    localparam logic [6:0] GL [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0100000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [6:0]  BL   = 7'b1111111;
    localparam logic [6:0]  DS   = 7'b0111111;
    localparam logic [55:0] ALL1 = {56{1'b1}};

    logic              clk;
    logic              rst_n;
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              mode;
    logic              blank_lz;
    logic              blink_en;
    logic              overflow;
    logic [55:0]       seg;

    int checks   = 0;
    int failures = 0;

    logic [55:0] cur;
    logic [55:0] all0;
    logic [55:0] exp_img;
    int          n;

    seg7_display_ctrl #(
        .DATA_W     (DATA_W),
        .NUM_DIGITS (NUM_DIGITS),
        .BLINK_DIV  (BLINK_DIV)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (valid),
        .o_ready    (ready),
        .i_data     (data),
        .i_mode     (mode),
        .i_blank_lz (blank_lz),
        .i_blink_en (blink_en),
        .o_overflow (overflow),
        .o_seg      (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [55:0] img(input logic [6:0] d7, input logic [6:0] d6,
                                        input logic [6:0] d5, input logic [6:0] d4,
                                        input logic [6:0] d3, input logic [6:0] d2,
                                        input logic [6:0] d1, input logic [6:0] d0);
        return {d7, d6, d5, d4, d3, d2, d1, d0};
    endfunction

    task automatic send(input logic [DATA_W-1:0] v, input logic m, input logic lz);
        @(negedge clk);
        valid    = 1'b1;
        data     = v;
        mode     = m;
        blank_lz = lz;
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    // Counts not-ready cycles until o_ready returns; the display must not move meanwhile.
    task automatic wait_ready(input string tag, input int exp_cycles, input logic [55:0] hold);
        int  cnt;
        logic early;
        cnt   = 0;
        early = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ready) break;
            cnt++;
            if (seg !== hold) early = 1'b1;
        end
        check({tag, "_lat"}, 64'(cnt), 64'(exp_cycles));
        check({tag, "_hold"}, 64'(early), 64'(0));
    endtask

    initial begin
        all0     = {8{GL[0]}};
        rst_n    = 1'b0;
        valid    = 1'b0;
        data     = '0;
        mode     = 1'b0;
        blank_lz = 1'b0;
        blink_en = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            valid = ~valid;
            data  = 32'h0000FFFF;
            @(negedge clk);
            check("rst_ready", 64'(ready), 64'(1));
            check("rst_seg", 64'(seg), 64'(all0));
        end
        check("rst_ovf", 64'(overflow), 64'(0));
        valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(ready), 64'(1));
        check("post_rst_seg", 64'(seg), 64'(all0));
        cur = all0;

        send(32'h0000BEEF, 1'b0, 1'b1);
        wait_ready("hex_beef", 1, cur);
        exp_img = img(BL, BL, BL, BL, GL[11], GL[14], GL[14], GL[15]);
        check("hex_beef_seg", 64'(seg), 64'(exp_img));
        cur = exp_img;

        send(32'h00A00C05, 1'b0, 1'b1);
        wait_ready("hex_inner0", 1, cur);
        exp_img = img(BL, BL, GL[10], GL[0], GL[0], GL[12], GL[0], GL[5]);
        check("hex_inner0_seg", 64'(seg), 64'(exp_img));
        cur = exp_img;

        send(32'd12345678, 1'b1, 1'b0);
        wait_ready("dec_12345678", 33, cur);
        exp_img = img(GL[1], GL[2], GL[3], GL[4], GL[5], GL[6], GL[7], GL[8]);
        check("dec_12345678_seg", 64'(seg), 64'(exp_img));
        check("dec_12345678_ovf", 64'(overflow), 64'(0));
        cur = exp_img;

        send(32'd100000000, 1'b1, 1'b0);
        wait_ready("dec_ovf", 33, cur);
        check("dec_ovf_flag", 64'(overflow), 64'(1));
        check("dec_ovf_seg", 64'(seg), 64'({8{DS}}));
        cur = {8{DS}};

        send(32'd12345678, 1'b1, 1'b0);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_seg", 64'(seg), 64'(all0));
        check("midrst_ovf", 64'(overflow), 64'(0));
        check("midrst_ready", 64'(ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        cur = all0;

        send(32'h0, 1'b0, 1'b1);
        wait_ready("hex_zero", 1, cur);
        exp_img = img(BL, BL, BL, BL, BL, BL, BL, GL[0]);
        check("hex_zero_seg", 64'(seg), 64'(exp_img));
        check("hex_zero_ovf", 64'(overflow), 64'(0));
        cur = exp_img;

        send(32'd42, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            valid = (i % 2 == 0);
            data  = 32'd99;
            mode  = 1'b0;
        end
        valid = 1'b0;
        wait_ready("dec_pulse", 23, cur);
        exp_img = img(BL, BL, BL, BL, BL, BL, GL[4], GL[2]);
        check("dec_pulse_seg", 64'(seg), 64'(exp_img));
        repeat (3) @(negedge clk);
        check("dec_pulse_idle_ready", 64'(ready), 64'(1));
        check("dec_pulse_idle_seg", 64'(seg), 64'(exp_img));
        cur = exp_img;

        @(negedge clk);
        blink_en = 1'b1;
        #1;
        n = 0;
        while (seg !== ALL1 && n < 20) begin @(negedge clk); n++; end
        n = 0;
        while (seg === ALL1 && n < 20) begin @(negedge clk); n++; end
        check("blink_on_val", 64'(seg), 64'(cur));
        n = 0;
        while (seg !== ALL1 && n < 20) begin @(negedge clk); n++; end
        check("blink_on_len", 64'(n), 64'(4));
        n = 0;
        while (seg === ALL1 && n < 20) begin @(negedge clk); n++; end
        check("blink_off_len", 64'(n), 64'(4));
        n = 0;
        while (seg !== ALL1 && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        check("blink_mid_off", 64'(seg), 64'(ALL1));
        blink_en = 1'b0;
        #1;
        check("blink_release_now", 64'(seg), 64'(cur));
        @(negedge clk);
        check("blink_release_next", 64'(seg), 64'(cur));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
